// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between N_REQ byte producers. In IDLE
//            a round-robin arbiter picks a winner and latches its byte. A
//            sequencer then pulses uart_start and follows uart_busy until the
//            frame ends. It reports tx_done on completion, or tx_err if busy
//            never rises.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            req_valid/ready  - per-requester handshake (ready is one-hot)
//            req_data         - requester i byte at [8*i+7:8*i]
//            req_lock         - keep priority after grant (UART_ARB_LOCK_EN)
//            uart_din/start   - byte and one-cycle start pulse to the UART
//            uart_busy        - UART busy indication
//            grant_id         - index of last/current winner
//            active           - high whenever the sequencer is not idle
//            tx_done/tx_err   - one-cycle completion / busy-timeout pulses
// Option   : `define UART_ARB_LOCK_EN adds req_lock (sticky priority)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int WAIT_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]     req_lock,
`endif
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           uart_din,
    output logic                 uart_start,
    input  logic                 uart_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic                 tx_done,
    output logic                 tx_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [3:0]      c_wait_last = 4'(WAIT_MAX - 1);
    localparam logic [ID_W-1:0] c_last_idx  = ID_W'(N_REQ - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [7:0]      din_q, din_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic            w_done, w_err;

    // Arbitration signals
    logic [N_REQ-1:0]            w_upper;
    logic [N_REQ-1:0]            w_pick;
    logic [N_REQ-1:0]            w_onehot;
    logic [ID_W-1:0][N_REQ-1:0]  w_isel;
    logic [7:0][N_REQ-1:0]       w_dsel;
    logic [ID_W-1:0]             w_win_idx;
    logic [7:0]                  w_win_data;
    logic                        w_any;
    logic                        w_lock_win;

    // Round-robin: requesters at or above rr_ptr take precedence; if none of
    // them is valid the scan wraps to the lowest valid index. The lowest set
    // bit of the chosen vector is isolated with x & -x.
    genvar gi, gb;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_upper
            assign w_upper[gi] = req_valid[gi] && (ID_W'(gi) >= rr_ptr_q);
        end
    endgenerate

    assign w_any    = |req_valid;
    assign w_pick   = (|w_upper) ? w_upper : req_valid;
    assign w_onehot = w_pick & (-w_pick);

    // One-hot to index / byte mux built as per-bit OR reductions.
    generate
        for (gb = 0; gb < ID_W; gb++) begin : g_idx_bit
            for (gi = 0; gi < N_REQ; gi++) begin : g_idx_req
                assign w_isel[gb][gi] = w_onehot[gi] & 1'(((gi >> gb) & 1));
            end
            assign w_win_idx[gb] = |w_isel[gb];
        end
        for (gb = 0; gb < 8; gb++) begin : g_dat_bit
            for (gi = 0; gi < N_REQ; gi++) begin : g_dat_req
                assign w_dsel[gb][gi] = w_onehot[gi] & req_data[8*gi + gb];
            end
            assign w_win_data[gb] = |w_dsel[gb];
        end
    endgenerate

`ifdef UART_ARB_LOCK_EN
    assign w_lock_win = |(w_onehot & req_lock);
`else
    assign w_lock_win = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        din_d    = din_q;
        wcnt_d   = wcnt_q;
        w_done   = 1'b0;
        w_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    din_d   = w_win_data;
                    grant_d = w_win_idx;
                    state_d = LAUNCH;
                    if (w_lock_win) begin
                        rr_ptr_d = w_win_idx;
                    end else if (w_win_idx == c_last_idx) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = w_win_idx + ID_W'(1);
                    end
                end
            end
            LAUNCH: begin
                wcnt_d  = 4'd0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = WAIT_DONE;
                end else if (wcnt_q == c_wait_last) begin
                    w_err   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    w_done  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            din_q    <= 8'h00;
            wcnt_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            din_q    <= din_d;
            wcnt_q   <= wcnt_d;
        end
    end

    // Pulses are masked during reset so an abandoned transfer reports nothing.
    assign req_ready  = (state_q == IDLE && !rst) ? w_onehot : '0;
    assign uart_start = (state_q == LAUNCH) && !rst;
    assign tx_done    = w_done && !rst;
    assign tx_err     = w_err && !rst;
    assign uart_din   = din_q;
    assign grant_id   = grant_q;
    assign active     = (state_q != IDLE);

endmodule
`default_nettype wire
